// File: rtl/iob_ddr_deser.sv
// rtl/iob_ddr_deser.sv - DDR input deserializer with RATIO:1 beat packing and a 2-entry output buffer.
// Falling-edge beats land in a negedge register; pairs are packed on the posedge domain.
module iob_ddr_deser #(
    parameter int DATA_W  = 8,
    parameter int RATIO   = 4,
    parameter int RST_VAL = 0
) (
    input  logic                       clk_i,
    input  logic                       arst_i,
    input  logic                       cke_i,
    input  logic                       rst_i,
    input  logic                       en_i,
    input  logic [DATA_W-1:0]          ddr_data_i,
    input  logic                       ddr_valid_i,
    output logic [DATA_W*RATIO-1:0]    data_o,
    output logic                       valid_o,
    input  logic                       ready_i,
    output logic                       overflow_o
);

    localparam int PAIR_W = 2 * DATA_W;
    localparam int WORD_W = DATA_W * RATIO;
    localparam int NPAIR  = RATIO / 2;
    localparam int CNT_W  = (NPAIR > 1) ? $clog2(NPAIR) : 1;
    localparam logic [DATA_W-1:0] RST_Q    = DATA_W'(RST_VAL);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(NPAIR - 1);

    logic [DATA_W-1:0] r_neg;
    logic [DATA_W-1:0] r_pos;
    logic              r_vld;
    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] r_mem [2];
    logic              r_wptr;
    logic              r_rptr;
    logic [1:0]        r_count;
    logic [WORD_W-1:0] r_data;
    logic              r_ovf;

    logic [WORD_W-1:0] w_word;
    logic [WORD_W-1:0] w_head;
    logic              w_push_pair;
    logic              w_done;
    logic              w_pop;
    logic              w_full;
    logic              w_wr;
    logic              w_drop;

    // Fall beat capture; shares cke/sync-reset behaviour with the posedge side.
    always_ff @(negedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_neg <= RST_Q;
        end else if (cke_i) begin
            if (rst_i) r_neg <= RST_Q;
            else       r_neg <= ddr_data_i;
        end
    end

    // The completing pair is merged combinationally so the word reaches the FIFO on the same edge.
    always_comb begin
        w_word = r_word;
        w_word[int'(r_cnt)*PAIR_W +: PAIR_W] = {r_neg, r_pos};
    end

    assign w_push_pair = r_vld & en_i;
    assign w_done      = w_push_pair & (r_cnt == CNT_LAST);
    assign w_pop       = (r_count != 2'd0) & ready_i;
    assign w_full      = (r_count == 2'd2);
    assign w_wr        = w_done & (~w_full | w_pop);
    assign w_drop      = w_done & w_full & ~w_pop;

    always_comb begin
        w_head = r_data;
        if (w_pop) begin
            if (w_full)    w_head = r_mem[~r_rptr];
            else if (w_wr) w_head = w_word;
        end else if ((r_count == 2'd0) && w_wr) begin
            w_head = w_word;
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            r_pos    <= RST_Q;
            r_vld    <= 1'b0;
            r_cnt    <= '0;
            r_word   <= '0;
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wptr   <= 1'b0;
            r_rptr   <= 1'b0;
            r_count  <= 2'd0;
            r_data   <= '0;
            r_ovf    <= 1'b0;
        end else if (cke_i) begin
            if (rst_i) begin
                r_pos    <= RST_Q;
                r_vld    <= 1'b0;
                r_cnt    <= '0;
                r_word   <= '0;
                r_mem[0] <= '0;
                r_mem[1] <= '0;
                r_wptr   <= 1'b0;
                r_rptr   <= 1'b0;
                r_count  <= 2'd0;
                r_data   <= '0;
                r_ovf    <= 1'b0;
            end else begin
                r_pos <= ddr_data_i;
                r_vld <= ddr_valid_i & en_i;
                // Dropping en_i abandons any partial word, including a pair pending this edge.
                if (!en_i) begin
                    r_cnt <= '0;
                end else if (r_vld) begin
                    r_cnt  <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
                    r_word <= w_word;
                end
                if (w_wr) begin
                    r_mem[r_wptr] <= w_word;
                    r_wptr        <= ~r_wptr;
                end
                if (w_pop) r_rptr <= ~r_rptr;
                if (w_wr && !w_pop)      r_count <= r_count + 2'd1;
                else if (!w_wr && w_pop) r_count <= r_count - 2'd1;
                r_data <= w_head;
                if (w_drop) r_ovf <= 1'b1;
            end
        end
    end

    assign data_o     = r_data;
    assign valid_o    = (r_count != 2'd0);
    assign overflow_o = r_ovf;

endmodule

// File: tb/tb_iob_ddr_deser.sv
// tb/tb_iob_ddr_deser.sv - directed self-checking bench for iob_ddr_deser (DATA_W=8, RATIO=4).
module tb_iob_ddr_deser;

    logic        clk_i = 1'b0;
    logic        arst_i;
    logic        cke_i;
    logic        rst_i;
    logic        en_i;
    logic [7:0]  ddr_data_i;
    logic        ddr_valid_i;
    logic [31:0] data_o;
    logic        valid_o;
    logic        ready_i;
    logic        overflow_o;

    int tests = 0;
    int fails = 0;

    iob_ddr_deser #(.DATA_W(8), .RATIO(4), .RST_VAL(0)) dut (
        .clk_i       (clk_i),
        .arst_i      (arst_i),
        .cke_i       (cke_i),
        .rst_i       (rst_i),
        .en_i        (en_i),
        .ddr_data_i  (ddr_data_i),
        .ddr_valid_i (ddr_valid_i),
        .data_o      (data_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .overflow_o  (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One DDR cycle: rise beat before the posedge, fall beat before the next negedge.
    task automatic cyc(input logic [7:0] r, input logic [7:0] f, input logic v, input logic c);
        @(negedge clk_i);
        #2;
        ddr_data_i  = r;
        ddr_valid_i = v;
        cke_i       = c;
        @(posedge clk_i);
        #2;
        ddr_data_i  = f;
    endtask

    function automatic logic [31:0] wexp(input int b);
        wexp = {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
    endfunction

    initial begin
        arst_i = 1'b1; cke_i = 1'b1; rst_i = 1'b0; en_i = 1'b1;
        ddr_data_i = 8'h00; ddr_valid_i = 1'b0; ready_i = 1'b1;
        #11;
        chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_ovf", overflow_o, 0);
        #1 arst_i = 1'b0;

        // single word latency
        cyc(8'hA0, 8'hA1, 1'b1, 1'b1);
        cyc(8'hA2, 8'hA3, 1'b1, 1'b1);
        chk("lat_not_early", valid_o, 0);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        chk("lat_valid", valid_o, 1);
        chk("lat_data", data_o, 32'hA3A2A1A0);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        chk("lat_one_cycle", valid_o, 0);
        chk("lat_hold", data_o, 32'hA3A2A1A0);

        // continuous stream
        for (int i = 0; i < 10; i++) begin
            if (i < 8) cyc(8'(2*i), 8'(2*i+1), 1'b1, 1'b1);
            else       cyc(8'h00, 8'h00, 1'b0, 1'b1);
            if (i >= 2 && (i % 2) == 0) begin
                chk("stream_valid", valid_o, 1);
                chk("stream_data", data_o, wexp(2*i - 4));
            end else if (i >= 3) begin
                chk("stream_gap", valid_o, 0);
            end
        end
        chk("stream_ovf", overflow_o, 0);

        // backpressure: third word dropped
        ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i < 6) cyc(8'(2*i), 8'(2*i+1), 1'b1, 1'b1);
            else       cyc(8'h00, 8'h00, 1'b0, 1'b1);
            if (i == 5) chk("bp_no_ovf_yet", overflow_o, 0);
        end
        chk("bp_ovf", overflow_o, 1);
        chk("bp_valid", valid_o, 1);
        chk("bp_head", data_o, wexp(0));
        ready_i = 1'b1;
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        chk("bp_second", data_o, wexp(4));
        chk("bp_second_valid", valid_o, 1);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        chk("bp_drained", valid_o, 0);
        chk("bp_ovf_sticky", overflow_o, 1);
        chk("bp_empty_hold", data_o, wexp(4));
        rst_i = 1'b1;
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        rst_i = 1'b0;
        chk("srst_ovf", overflow_o, 0);
        chk("srst_data", data_o, 0);
        chk("srst_valid", valid_o, 0);

        // full FIFO, pop on the completing push edge
        ready_i = 1'b0;
        for (int i = 0; i < 6; i++) cyc(8'(2*i), 8'(2*i+1), 1'b1, 1'b1);
        chk("full_head", data_o, wexp(0));
        ready_i = 1'b1;
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        chk("full_pp_ovf", overflow_o, 0);
        chk("full_pp_valid", valid_o, 1);
        chk("full_pp_data1", data_o, wexp(4));
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        chk("full_pp_data2", data_o, wexp(8));
        chk("full_pp_valid2", valid_o, 1);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        chk("full_pp_empty", valid_o, 0);

        // en_i drop discards the partial word
        cyc(8'h11, 8'h22, 1'b1, 1'b1);
        en_i = 1'b0;
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        en_i = 1'b1;
        cyc(8'h33, 8'h34, 1'b1, 1'b1);
        chk("en_no_partial1", valid_o, 0);
        cyc(8'h35, 8'h36, 1'b1, 1'b1);
        chk("en_no_partial2", valid_o, 0);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        chk("en_valid", valid_o, 1);
        chk("en_data", data_o, 32'h36353433);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        chk("en_single", valid_o, 0);

        // async reset mid-word
        ready_i = 1'b0;
        cyc(8'hD0, 8'hD1, 1'b1, 1'b1);
        cyc(8'hD2, 8'hD3, 1'b1, 1'b1);
        cyc(8'hE0, 8'hE1, 1'b1, 1'b1);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        chk("arst_pre_valid", valid_o, 1);
        chk("arst_pre_data", data_o, 32'hD3D2D1D0);
        arst_i = 1'b1;
        #1;
        chk("arst_valid", valid_o, 0);
        chk("arst_data", data_o, 0);
        chk("arst_ovf", overflow_o, 0);
        #1 arst_i = 1'b0;
        ready_i = 1'b1;
        cyc(8'hF0, 8'hF1, 1'b1, 1'b1);
        cyc(8'hF2, 8'hF3, 1'b1, 1'b1);
        chk("arst_no_stale", valid_o, 0);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        chk("arst_fresh_valid", valid_o, 1);
        chk("arst_fresh_data", data_o, 32'hF3F2F1F0);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);

        // cke_i low for 5 cycles mid-word
        cyc(8'h40, 8'h41, 1'b1, 1'b1);
        cyc(8'h42, 8'h43, 1'b1, 1'b1);
        cyc(8'h50, 8'h51, 1'b1, 1'b1);
        chk("cke_pre_valid", valid_o, 1);
        chk("cke_pre_data", data_o, 32'h43424140);
        for (int i = 0; i < 5; i++) cyc(8'h99, 8'h98, 1'b1, 1'b0);
        chk("cke_frozen_valid", valid_o, 1);
        chk("cke_frozen_data", data_o, 32'h43424140);
        cyc(8'h52, 8'h53, 1'b1, 1'b1);
        chk("cke_resume_pop", valid_o, 0);
        cyc(8'h00, 8'h00, 1'b0, 1'b1);
        chk("cke_word_valid", valid_o, 1);
        chk("cke_word_data", data_o, 32'h53525150);
        chk("cke_ovf", overflow_o, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
